dig_freq_synth: RTL and testbench

DIG_FREQ_SYNTH -- requirements
Module: dig_freq_synth

---
 rtl/dig_freq_synth.sv | 120 ++++++++++++
 tb/tb_dig_freq_synth.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dig_freq_synth.sv
// Digital frequency synthesizer: square wave with half-period 32-code, codes via valid/ready.
// Optional DFS_PERIOD_CNT_EN adds an 8-bit count of output periods (period_cnt).
module dig_freq_synth (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       fout,
  output logic       wrap,
  output logic [4:0] active_code
`ifdef DFS_PERIOD_CNT_EN
  ,
  output logic [7:0] period_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;
  logic       r_fout, w_fout_nxt;
  logic       r_wrap, w_wrap_nxt;
  logic [4:0] r_active, w_active_nxt;
  logic [4:0] r_pend, w_pend_nxt;
  logic       r_pend_full, w_pend_full_nxt;
  logic [5:0] w_half;
  logic       w_last;
  logic       w_xfer;

  assign w_half = 6'd32 - {1'b0, r_active};
  assign w_last = (r_cnt == (w_half - 6'd1));
  assign w_xfer = code_valid & ~r_pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_fout      <= 1'b0;
      r_wrap      <= 1'b0;
      r_active    <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fout      <= w_fout_nxt;
      r_wrap      <= w_wrap_nxt;
      r_active    <= w_active_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_full <= w_pend_full_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_fout_nxt      = 1'b0;
    w_wrap_nxt      = 1'b0;
    w_active_nxt    = r_active;
    w_pend_nxt      = r_pend;
    w_pend_full_nxt = r_pend_full;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_active_nxt = code_in;
        if (en) w_state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          // Leaving RUN: any queued code takes effect now so nothing is stranded in IDLE.
          w_state_nxt = IDLE;
          if (r_pend_full) begin
            w_active_nxt    = r_pend;
            w_pend_full_nxt = 1'b0;
          end else if (w_xfer) begin
            w_active_nxt = code_in;
          end
        end else begin
          if (w_last) begin
            w_fout_nxt = ~r_fout;
            if (!r_fout) begin
              // Rising toggle is the period boundary; only a code queued before it applies.
              w_wrap_nxt = 1'b1;
              if (r_pend_full) begin
                w_active_nxt    = r_pend;
                w_pend_full_nxt = 1'b0;
              end
            end
          end else begin
            w_cnt_nxt  = r_cnt + 6'd1;
            w_fout_nxt = r_fout;
          end
          if (w_xfer) begin
            w_pend_nxt      = code_in;
            w_pend_full_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign code_ready  = ~r_pend_full;
  assign fout        = r_fout;
  assign wrap        = r_wrap;
  assign active_code = r_active;

`ifdef DFS_PERIOD_CNT_EN
  logic [7:0] r_pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pcnt <= '0;
    else if (w_wrap_nxt) r_pcnt <= r_pcnt + 8'd1;
  end

  assign period_cnt = r_pcnt;
`endif

endmodule

// File: tb/tb_dig_freq_synth.sv
// Directed self-checking bench for dig_freq_synth (define DFS_PERIOD_CNT_EN to cover period_cnt).
module tb_dig_freq_synth;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic       fout;
  logic       wrap;
  logic [4:0] active_code;
`ifdef DFS_PERIOD_CNT_EN
  logic [7:0] period_cnt;
`endif

  int errors = 0;
  int checks = 0;

  dig_freq_synth dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fout       (fout),
    .wrap       (wrap),
    .active_code(active_code)
`ifdef DFS_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns to IDLE, loads a code there, then raises en; returns just after the RUN-entry edge.
  task automatic run_start(input logic [4:0] code);
    en = 1'b0; code_valid = 1'b0;
    tick;
    code_valid = 1'b1; code_in = code;
    tick;
    code_valid = 1'b0; en = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (fout !== 1'b0) begin errors++; $display("FAIL rst_fout got=%b exp=0", fout); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got=%b exp=0", wrap); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", code_ready); end
    checks++; if (active_code !== 5'd0) begin errors++; $display("FAIL rst_active got=%0d exp=0", active_code); end
    tick;
    rst_n = 1'b1;
    // Mid-run with code 20 (N=12) and a pending code queued, then async reset.
    run_start(5'd20);
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (k == 13) begin code_valid = 1'b1; code_in = 5'd5; end
      if (k == 14) code_valid = 1'b0;
    end
    checks++; if (fout !== 1'b1) begin errors++; $display("FAIL prerst_fout got=%b exp=1", fout); end
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL prerst_ready got=%b exp=0", code_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fout !== 1'b0) begin errors++; $display("FAIL midrst_fout got=%b exp=0", fout); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL midrst_wrap got=%b exp=0", wrap); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", code_ready); end
    checks++; if (active_code !== 5'd0) begin errors++; $display("FAIL midrst_active got=%0d exp=0", active_code); end
    en = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++; if (active_code !== 5'd0) begin errors++; $display("FAIL postrst_active got=%0d exp=0", active_code); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL postrst_ready got=%b exp=1", code_ready); end
  endtask

  task automatic test_fast;
    en = 1'b0; code_valid = 1'b0;
    tick;
    code_valid = 1'b1; code_in = 5'd31;
    tick;
    checks++; if (active_code !== 5'd31) begin errors++; $display("FAIL idle_load got=%0d exp=31", active_code); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", code_ready); end
    code_valid = 1'b0; en = 1'b1;
    tick;
    checks++; if (fout !== 1'b0) begin errors++; $display("FAIL fast_entry_fout got=%b exp=0", fout); end
    for (int k = 1; k <= 8; k++) begin
      tick;
      checks++; if (fout !== k[0]) begin errors++; $display("FAIL fast_fout k=%0d got=%b exp=%b", k, fout, k[0]); end
      checks++; if (wrap !== k[0]) begin errors++; $display("FAIL fast_wrap k=%0d got=%b exp=%b", k, wrap, k[0]); end
    end
    en = 1'b0;
    tick;
    checks++; if (fout !== 1'b0) begin errors++; $display("FAIL fast_stop_fout got=%b exp=0", fout); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL fast_stop_wrap got=%b exp=0", wrap); end
  endtask

  // Code 28 (N=4) rises at k=4,12; code 24 queued at edge 6 applies at 12, then N=8: fall 20, rise 28.
  task automatic test_pending;
    logic ef, ew, er;
    logic [4:0] ea;
    run_start(5'd28);
    for (int k = 1; k <= 30; k++) begin
      tick;
      ef = ((k >= 4) && (k < 8)) || ((k >= 12) && (k < 20)) || (k >= 28);
      ew = (k == 4) || (k == 12) || (k == 28);
      er = !((k >= 6) && (k < 12));
      ea = (k < 12) ? 5'd28 : 5'd24;
      checks++; if (fout !== ef) begin errors++; $display("FAIL pend_fout k=%0d got=%b exp=%b", k, fout, ef); end
      checks++; if (wrap !== ew) begin errors++; $display("FAIL pend_wrap k=%0d got=%b exp=%b", k, wrap, ew); end
      checks++; if (code_ready !== er) begin errors++; $display("FAIL pend_ready k=%0d got=%b exp=%b", k, code_ready, er); end
      checks++; if (active_code !== ea) begin errors++; $display("FAIL pend_active k=%0d got=%0d exp=%0d", k, active_code, ea); end
      if (k == 5) begin code_valid = 1'b1; code_in = 5'd24; end
      if (k == 6) code_valid = 1'b0;
    end
  endtask

  // Code 10 held valid from edge 7: ignored while full, taken at edge 13, applied at rise k=28.
  task automatic test_no_overwrite;
    logic er;
    logic [4:0] ea;
    run_start(5'd28);
    for (int k = 1; k <= 30; k++) begin
      tick;
      er = !((k >= 6) && (k < 12)) && !((k >= 13) && (k < 28));
      ea = (k < 12) ? 5'd28 : ((k < 28) ? 5'd24 : 5'd10);
      checks++; if (code_ready !== er) begin errors++; $display("FAIL novw_ready k=%0d got=%b exp=%b", k, code_ready, er); end
      checks++; if (active_code !== ea) begin errors++; $display("FAIL novw_active k=%0d got=%0d exp=%0d", k, active_code, ea); end
      if (k == 5) begin code_valid = 1'b1; code_in = 5'd24; end
      if (k == 6) code_in = 5'd10;
      if (k == 13) code_valid = 1'b0;
    end
    checks++; if (fout !== 1'b1) begin errors++; $display("FAIL novw_fout got=%b exp=1", fout); end
  endtask

  // Transfer on the boundary edge (k=4) must wait for the next boundary (k=12).
  task automatic test_boundary_xfer;
    logic er;
    logic [4:0] ea;
    run_start(5'd28);
    for (int k = 1; k <= 14; k++) begin
      tick;
      er = !((k >= 4) && (k < 12));
      ea = (k < 12) ? 5'd28 : 5'd24;
      checks++; if (code_ready !== er) begin errors++; $display("FAIL bnd_ready k=%0d got=%b exp=%b", k, code_ready, er); end
      checks++; if (active_code !== ea) begin errors++; $display("FAIL bnd_active k=%0d got=%0d exp=%0d", k, active_code, ea); end
      if (k == 3) begin code_valid = 1'b1; code_in = 5'd24; end
      if (k == 4) code_valid = 1'b0;
    end
  endtask

  task automatic test_restart;
    run_start(5'd16);
    for (int k = 1; k <= 21; k++) begin
      tick;
      if (k == 16) begin
        checks++; if (fout !== 1'b1) begin errors++; $display("FAIL rst16_rise got=%b exp=1", fout); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL rst16_wrap got=%b exp=1", wrap); end
      end
    end
    en = 1'b0;
    tick;
    checks++; if (fout !== 1'b0) begin errors++; $display("FAIL drop_fout got=%b exp=0", fout); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL drop_wrap got=%b exp=0", wrap); end
    en = 1'b1;
    tick;
    for (int k = 1; k <= 16; k++) begin
      tick;
      checks++; if (fout !== (k == 16)) begin errors++; $display("FAIL reentry_fout k=%0d got=%b exp=%b", k, fout, (k == 16)); end
      checks++; if (wrap !== (k == 16)) begin errors++; $display("FAIL reentry_wrap k=%0d got=%b exp=%b", k, wrap, (k == 16)); end
    end
    en = 1'b0;
    tick;
  endtask

`ifdef DFS_PERIOD_CNT_EN
  // Code 31: wrap pulses at odd k, so pulse 256 is at k=511 and pulse 266 at k=531.
  task automatic test_period_cnt;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    run_start(5'd31);
    for (int k = 1; k <= 531; k++) begin
      tick;
      if (k == 510) begin
        checks++; if (period_cnt !== 8'd255) begin errors++; $display("FAIL pcnt_255 got=%0d exp=255", period_cnt); end
      end
      if (k == 511) begin
        checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL pcnt_wrap got=%0d exp=0", period_cnt); end
      end
      if (k == 531) begin
        checks++; if (period_cnt !== 8'd10) begin errors++; $display("FAIL pcnt_10 got=%0d exp=10", period_cnt); end
      end
    end
    en = 1'b0;
    tick; tick;
    checks++; if (period_cnt !== 8'd10) begin errors++; $display("FAIL pcnt_hold got=%0d exp=10", period_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; code_in = '0; code_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset;
    test_fast;
    test_pending;
    test_no_overwrite;
    test_boundary_xfer;
    test_restart;
`ifdef DFS_PERIOD_CNT_EN
    test_period_cnt;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
